// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32I core.
// Fetch-side enums, IF/ID bundle and the canonical NOP.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_t;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble(input logic [31:0] nop);
        ifid_t b;
        b.instr   = nop;
        b.pc      = '0;
        b.pcplus4 = '0;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
// Request is accepted and data returned in the same ImemReady cycle.
interface fetch_unit_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        output ImemRData
    );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID-shaped register with bubble > hold > load priority.
// Also used as the one-entry response skid buffer.
module ifid_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t q_q;
    ifid_t q_d;

    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d = ifid_bubble(NOP);
        end else if (!hold_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= ifid_bubble(NOP);
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, imem handshake, skid buffer, IF/ID.
// DROP state swallows a response whose request was overtaken by a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   PCSrcE,
    input  logic [31:0]  PCTargetE,
    input  logic [31:0]  ALUResultE,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    fetch_unit_if.master imem,
    output logic [31:0]  PCF,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD
);

    import pipeline_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic         out_q, out_d;

    logic         redirect;
    logic [31:0]  target;
    logic         in_drop;
    logic         req;
    logic         accept;

    ifid_t        resp;
    ifid_t        buf_q;
    ifid_t        ifid_in;
    ifid_t        ifid_q;
    logic         buf_fill;
    logic         buf_bubble;
    logic         ifid_load;
    logic         ifid_bubble_en;

    always_comb begin
        redirect = 1'b0;
        target   = pcf_q + 32'd4;
        unique case (1'b1)
            (PCSrcE == PCSRC_TARGET): begin
                redirect = 1'b1;
                target   = PCTargetE;
            end
            (PCSrcE == PCSRC_JALR): begin
                redirect = 1'b1;
                target   = ALUResultE & ~32'h1;
            end
            default: ;
        endcase
    end

    assign in_drop = (state_q == DROP);
    // Outstanding keeps the request alive even if StallF rises mid-wait.
    assign req     = in_drop || out_q || (!StallF && !buf_q.valid);
    assign accept  = req && imem.ImemReady;

    assign imem.ImemReq  = req;
    assign imem.ImemAddr = in_drop ? drop_addr_q : pcf_q;

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        drop_addr_d = drop_addr_q;
        out_d       = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pcf_d = target;
                    if (req && !imem.ImemReady) begin
                        state_d     = DROP;
                        drop_addr_d = pcf_q;
                    end
                end else begin
                    if (accept) begin
                        pcf_d = pcf_q + 32'd4;
                    end
                    out_d = req && !imem.ImemReady;
                end
            end
            DROP: begin
                if (redirect) begin
                    pcf_d = target;
                end
                if (imem.ImemReady) begin
                    state_d = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pcf_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
            out_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            drop_addr_q <= drop_addr_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        resp.instr   = imem.ImemRData;
        resp.pc      = pcf_q;
        resp.pcplus4 = pcf_q + 32'd4;
        resp.valid   = 1'b1;
    end

    assign buf_fill   = !in_drop && accept && !redirect && StallD;
    assign buf_bubble = redirect || FlushD || (!StallD && buf_q.valid);

    ifid_reg #(
        .NOP (NOP_INSTR)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (!buf_fill),
        .bubble_i (buf_bubble),
        .d_i      (resp),
        .q_o      (buf_q)
    );

    // A buffered response is always older than anything arriving now.
    assign ifid_in        = buf_q.valid ? buf_q : resp;
    assign ifid_load      = buf_q.valid || (!in_drop && accept);
    assign ifid_bubble_en = redirect || FlushD || in_drop
                          || (!StallD && !ifid_load);

    ifid_reg #(
        .NOP (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (StallD),
        .bubble_i (ifid_bubble_en),
        .d_i      (ifid_in),
        .q_o      (ifid_q)
    );

    assign PCF      = pcf_q;
    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pcplus4;
    assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a
// randomized run against a behavioural fetch-stage reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] ptarget;
    logic [31:0] alu;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    logic        rdy;
    logic        ovr_en;
    logic [31:0] ovr;
    logic [31:0] cur_rdata;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    bit          m_drop;
    bit          m_out;
    logic [63:0] m_skid[$];
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    bit          m_valid;

    fetch_unit_if imem();

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (pcsrc),
        .PCTargetE  (ptarget),
        .ALUResultE (alu),
        .StallF     (stall_f),
        .StallD     (stall_d),
        .FlushD     (flush_d),
        .imem       (imem),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic settle();
        #1;
        imem.ImemReady = rdy;
        cur_rdata = ovr_en ? ovr : mem_word(imem.ImemAddr);
        imem.ImemRData = cur_rdata;
        #1;
    endtask

    task automatic model_bubble();
        m_instr = NOP;
        m_pcd   = '0;
        m_valid = 0;
    endtask

    task automatic model_step();
        bit          was_drop;
        bit          redir;
        bit          req;
        bit          acc;
        logic [31:0] tgt;
        if (rst) begin
            m_pc   = RST_PC;
            m_drop = 0;
            m_out  = 0;
            m_skid.delete();
            model_bubble();
            return;
        end
        was_drop = m_drop;
        redir    = (pcsrc == 2'd1) || (pcsrc == 2'd2);
        tgt      = (pcsrc == 2'd1) ? ptarget : {alu[31:1], 1'b0};
        req      = m_drop || m_out || (!stall_f && m_skid.size() == 0);
        acc      = req && rdy;
        if (redir || flush_d || was_drop) begin
            model_bubble();
        end else if (!stall_d) begin
            if (m_skid.size() != 0) begin
                {m_instr, m_pcd} = m_skid[0];
                m_valid = 1;
            end else if (acc) begin
                m_instr = cur_rdata;
                m_pcd   = m_pc;
                m_valid = 1;
            end else begin
                model_bubble();
            end
        end
        if (redir || flush_d) begin
            m_skid.delete();
        end else if (!stall_d && m_skid.size() != 0) begin
            void'(m_skid.pop_front());
        end else if (!was_drop && acc && stall_d) begin
            m_skid.push_back({cur_rdata, m_pc});
        end
        m_out = !was_drop && !redir && req && !rdy;
        if (was_drop) begin
            if (rdy) m_drop = 0;
        end else if (redir && req && !rdy) begin
            m_drop  = 1;
            m_daddr = m_pc;
        end
        if (redir) m_pc = tgt;
        else if (!was_drop && acc) m_pc = m_pc + 32'd4;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1;
        settle(); tick(); tick();
        rst = 0;
        settle();
        checks++;
        if (imem.ImemReq !== 1'b1) begin
            errors++; $display("FAIL reset_req got=%b exp=1", imem.ImemReq);
        end
        checks++;
        if (imem.ImemAddr !== RST_PC) begin
            errors++; $display("FAIL reset_addr got=%h exp=%h", imem.ImemAddr, RST_PC);
        end
        checks++;
        if (PCF !== RST_PC) begin
            errors++; $display("FAIL reset_pcf got=%h exp=%h", PCF, RST_PC);
        end
        checks++;
        if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 0 || PCPlus4D !== 0) begin
            errors++;
            $display("FAIL reset_ifid got=%b/%h/%h/%h exp=0/%h/0/0",
                     ValidD, InstrD, PCD, PCPlus4D, NOP);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (imem.ImemAddr !== 32'(i * 4)) begin
                errors++; $display("FAIL seq_addr got=%h exp=%h", imem.ImemAddr, i * 4);
            end
            if (i > 0) begin
                checks++;
                if (ValidD !== 1'b1 || PCD !== 32'((i - 1) * 4)
                    || PCPlus4D !== 32'(i * 4)
                    || InstrD !== mem_word(32'((i - 1) * 4))) begin
                    errors++;
                    $display("FAIL seq_ifid got=%b/%h/%h exp=1/%h pc=%h",
                             ValidD, PCD, InstrD, mem_word(32'((i - 1) * 4)), (i - 1) * 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        bit found = 0;
        for (int i = 0; i < 16; i++) begin
            settle();
            if (imem.ImemAddr === 32'h20) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL branch_reach got=%h exp=00000020", imem.ImemAddr);
        end else begin
            pcsrc = 2'b01; ptarget = 32'h100;
            tick();
            pcsrc = 2'b00;
            settle();
            checks++;
            if (imem.ImemAddr !== 32'h100 || ValidD !== 1'b0) begin
                errors++;
                $display("FAIL branch_bubble got=%h/%b exp=00000100/0", imem.ImemAddr, ValidD);
            end
            tick();
            settle();
            checks++;
            if (PCD !== 32'h100 || ValidD !== 1'b1 || InstrD !== mem_word(32'h100)) begin
                errors++;
                $display("FAIL branch_target got=%h/%b/%h exp=00000100/1/%h",
                         PCD, ValidD, InstrD, mem_word(32'h100));
            end
        end
    endtask

    task automatic test_jalr();
        pcsrc = 2'b10; alu = 32'h203;
        settle(); tick();
        pcsrc = 2'b00;
        settle();
        checks++;
        if (PCF !== 32'h202 || imem.ImemAddr !== 32'h202) begin
            errors++; $display("FAIL jalr_pc got=%h/%h exp=00000202", PCF, imem.ImemAddr);
        end
        tick();
        settle();
        checks++;
        if (PCD !== 32'h202 || ValidD !== 1'b1) begin
            errors++; $display("FAIL jalr_pcd got=%h/%b exp=00000202/1", PCD, ValidD);
        end
    endtask

    task automatic test_redirect_wait();
        bit saw_dead = 0;
        pcsrc = 2'b01; ptarget = 32'h40; rdy = 1;
        settle(); tick();
        pcsrc = 2'b00; rdy = 0;
        settle();
        checks++;
        if (imem.ImemAddr !== 32'h40 || imem.ImemReq !== 1'b1) begin
            errors++;
            $display("FAIL wait_req got=%h/%b exp=00000040/1", imem.ImemAddr, imem.ImemReq);
        end
        tick();
        pcsrc = 2'b01; ptarget = 32'h80;
        settle(); tick();
        pcsrc = 2'b00;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (imem.ImemAddr !== 32'h40 || imem.ImemReq !== 1'b1
                || ValidD !== 1'b0 || PCF !== 32'h80) begin
                errors++;
                $display("FAIL drop_hold got=%h/%b/%b/%h exp=00000040/1/0/00000080",
                         imem.ImemAddr, imem.ImemReq, ValidD, PCF);
            end
            tick();
        end
        rdy = 1; ovr_en = 1; ovr = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (imem.ImemAddr !== 32'h40) begin
            errors++; $display("FAIL drop_ready_addr got=%h exp=00000040", imem.ImemAddr);
        end
        tick();
        ovr_en = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (ValidD === 1'b1 && InstrD === 32'hDEAD_BEEF) saw_dead = 1;
            if (i == 0) begin
                checks++;
                if (imem.ImemAddr !== 32'h80 || imem.ImemReq !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_next got=%h/%b exp=00000080/1",
                             imem.ImemAddr, imem.ImemReq);
                end
            end
            if (i == 1) begin
                checks++;
                if (PCD !== 32'h80 || ValidD !== 1'b1) begin
                    errors++; $display("FAIL drop_target got=%h/%b exp=00000080/1", PCD, ValidD);
                end
            end
            tick();
        end
        checks++;
        if (saw_dead) begin
            errors++; $display("FAIL drop_stale got=DEADBEEF valid exp=never");
        end
    endtask

    task automatic test_skid();
        pcsrc = 2'b01; ptarget = 32'h4; rdy = 1; stall_f = 0; stall_d = 0;
        settle(); tick();
        pcsrc = 2'b00;
        settle(); tick();
        rdy = 0; stall_d = 1;
        settle();
        checks++;
        if (imem.ImemAddr !== 32'h8 || imem.ImemReq !== 1'b1) begin
            errors++; $display("FAIL skid_req8 got=%h/%b exp=00000008/1", imem.ImemAddr, imem.ImemReq);
        end
        tick();
        stall_f = 1; rdy = 1;
        settle();
        checks++;
        if (imem.ImemReq !== 1'b1) begin
            errors++; $display("FAIL skid_outstanding got=%b exp=1", imem.ImemReq);
        end
        tick();
        settle();
        checks++;
        if (imem.ImemReq !== 1'b0 || PCD !== 32'h4 || ValidD !== 1'b1 || PCF !== 32'hC) begin
            errors++;
            $display("FAIL skid_hold got=%b/%h/%b/%h exp=0/00000004/1/0000000c",
                     imem.ImemReq, PCD, ValidD, PCF);
        end
        tick();
        stall_f = 0; stall_d = 0;
        settle();
        checks++;
        if (imem.ImemReq !== 1'b0) begin
            errors++; $display("FAIL skid_drain_req got=%b exp=0", imem.ImemReq);
        end
        tick();
        settle();
        checks++;
        if (PCD !== 32'h8 || ValidD !== 1'b1 || InstrD !== mem_word(32'h8)
            || imem.ImemAddr !== 32'hC || imem.ImemReq !== 1'b1) begin
            errors++;
            $display("FAIL skid_release got=%h/%b/%h/%h exp=00000008/1/%h/0000000c",
                     PCD, ValidD, InstrD, imem.ImemAddr, mem_word(32'h8));
        end
        tick();
    endtask

    task automatic test_wrap_reset();
        pcsrc = 2'b01; ptarget = 32'hFFFF_FFFC; rdy = 1;
        settle(); tick();
        pcsrc = 2'b00;
        settle();
        checks++;
        if (imem.ImemAddr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem.ImemAddr);
        end
        tick();
        settle();
        checks++;
        if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc got=%h/%h/%h exp=00000000/fffffffc/00000000",
                     PCF, PCD, PCPlus4D);
        end
        tick();
        rdy = 0;
        settle(); tick();
        rst = 1;
        settle(); tick();
        rst = 0;
        settle();
        checks++;
        if (PCF !== RST_PC || ValidD !== 1'b0 || imem.ImemReq !== 1'b1
            || imem.ImemAddr !== RST_PC) begin
            errors++;
            $display("FAIL midwait_reset got=%h/%b/%b/%h exp=%h/0/1/%h",
                     PCF, ValidD, imem.ImemReq, imem.ImemAddr, RST_PC, RST_PC);
        end
        rdy = 1;
    endtask

    task automatic test_random();
        int r;
        bit          e_req;
        logic [31:0] e_addr;
        for (int n = 0; n < 600; n++) begin
            rst     = (n == 0) || ($urandom_range(0, 99) == 0);
            stall_f = ($urandom_range(0, 4) == 0);
            stall_d = ($urandom_range(0, 4) == 0);
            flush_d = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 99);
            pcsrc   = (r < 80) ? 2'd0 : (r < 87) ? 2'd1 : (r < 94) ? 2'd2 : 2'd3;
            ptarget = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) ptarget = 32'hFFFF_FFF8;
            alu     = $urandom;
            rdy     = ($urandom_range(0, 9) < 6);
            settle();
            e_req  = m_drop || m_out || (!stall_f && m_skid.size() == 0);
            e_addr = m_drop ? m_daddr : m_pc;
            checks++;
            if (imem.ImemReq !== e_req) begin
                errors++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, imem.ImemReq, e_req);
            end
            checks++;
            if (e_req && imem.ImemAddr !== e_addr) begin
                errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem.ImemAddr, e_addr);
            end
            checks++;
            if (PCF !== m_pc) begin
                errors++; $display("FAIL rnd_pcf n=%0d got=%h exp=%h", n, PCF, m_pc);
            end
            checks++;
            if (ValidD !== m_valid || InstrD !== m_instr || PCD !== m_pcd
                || PCPlus4D !== (m_valid ? m_pcd + 32'd4 : 32'd0)) begin
                errors++;
                $display("FAIL rnd_ifid n=%0d got=%b/%h/%h/%h exp=%b/%h/%h",
                         n, ValidD, InstrD, PCD, PCPlus4D, m_valid, m_instr, m_pcd);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1; pcsrc = 0; ptarget = 0; alu = 0;
        stall_f = 0; stall_d = 0; flush_d = 0;
        rdy = 1; ovr_en = 0; ovr = 0; cur_rdata = 0;
        imem.ImemReady = 1'b0;
        imem.ImemRData = '0;
        m_pc = RST_PC; m_daddr = RST_PC; m_drop = 0; m_out = 0;
        m_instr = NOP; m_pcd = 0; m_valid = 0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_redirect_wait();
        test_skid();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RV32I core, sitting directly downstream of the execute-stage PC-source logic. It owns the PC register, picks the next PC from `PCSrcE`, and talks to instruction memory over a req/ready handshake. It also contains a one-entry skid buffer for responses that arrive while Decode is stalled, and it fills the IF/ID pipeline register. Redirects that arrive while a fetch is in flight are handled by a drop state, so a stale instruction never reaches Decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction placed in IF/ID on bubble, flush or reset (`addi x0,x0,0`).
- `clk` in 1: clock. One clock domain, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `PCSrcE` in 2: next-PC select.
  - 00: PC+4.
  - 01: `PCTargetE`.
  - 10: `ALUResultE & ~32'h1`.
  - 11: treated as 00.
- `PCTargetE` in 32: branch/JAL target from Execute.
- `ALUResultE` in 32: JALR target from Execute.
- `StallF` in 1: hazard unit; blocks issue of new requests.
- `StallD` in 1: hazard unit; holds IF/ID.
- `FlushD` in 1: hazard unit; bubbles IF/ID and clears the skid buffer.
- `ImemReq` out 1: fetch request valid.
- `ImemAddr` out 32: fetch address; stable while `ImemReq && !ImemReady`.
- `ImemReady` in 1: request accepted; `ImemRData` is valid in the same cycle.
- `ImemRData` in 32: fetched instruction.
- `PCF` out 32: current fetch PC (next address to request).
- `InstrD` out 32: IF/ID instruction.
- `PCD` out 32: IF/ID PC.
- `PCPlus4D` out 32: IF/ID PC+4.
- `ValidD` out 1: IF/ID holds a real instruction.

## Operation
- **Redirect.** `Redirect = (PCSrcE==01 || PCSrcE==10)`.
- **States.**
  - FETCH: normal operation.
  - DROP: the in-flight response must be discarded.
- **Registers.**
  - `PCF`.
  - `DropAddr`.
  - `Outstanding`: request raised and not yet accepted.
  - Skid buffer: `BufValid`, `BufInstr`, `BufPC`.
  - IF/ID register.
  - State.
- **`ImemReq` and `ImemAddr`.**
  - `ImemReq = (state==DROP) || Outstanding || (!StallF && !BufValid)`.
  - `ImemAddr = (state==DROP) ? DropAddr : PCF`.
- **FETCH, accept (`ImemReq && ImemReady`), no Redirect.**
  - `PCF <= PCF+4`.
  - If `!StallD && !BufValid`: IF/ID <= {`ImemRData`, `PCF`, `PCF+4`, 1}.
  - If `StallD`: the response goes into the skid buffer instead.
- **FETCH, accept with Redirect.**
  - `PCF <=` target.
  - Response is discarded.
  - IF/ID gets a bubble; buffer is cleared.
- **FETCH, Redirect with request pending but not accepted.**
  - `DropAddr <= PCF`, `PCF <=` target, go to DROP.
  - IF/ID gets a bubble; buffer is cleared.
- **FETCH, Redirect with no request.** `PCF <=` target; IF/ID gets a bubble.
- **DROP.**
  - `ImemReq` stays high on `DropAddr`.
  - On `ImemReady`: discard the data and go to FETCH.
  - A further Redirect in DROP overwrites `PCF` (latest wins) and stays in DROP.
  - ValidD is 0 throughout.
- **Skid buffer.**
  - When `!StallD && BufValid`: IF/ID <= {`BufInstr`, `BufPC`, `BufPC+4`, 1} and `BufValid <= 0`.
  - That cycle no new request issues, because `ImemReq` is evaluated on the current `BufValid`.
- **Bubble.** IF/ID = {`NOP_INSTR`, 0, 0, 0}.
- **IF/ID priority.** Redirect or `FlushD` (bubble) > `StallD` (hold) > load.
- **Redirect vs stall.** Redirect takes priority over `StallF`; the PC is always updated on Redirect.
- **Arithmetic.** All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- **Reset values.**
  - `PCF = RESET_PC`; state FETCH.
  - `Outstanding = 0`, `BufValid = 0`.
  - IF/ID = bubble.
  - `ImemReq` is 1 in the first cycle after reset, since it is combinational from the reset state.
- **Latency with a single-cycle memory** (`ImemReady` tied high): instruction at `PCF` appears in `InstrD` one cycle later; throughput is 1 per cycle.
- **Redirect penalty.**
  - Seen in cycle t; first target fetch issues in t+1.
  - Target instruction reaches `ValidD` at t+2, or after the dropped response when in DROP.
- **Reset mid-operation.** Returns to the reset state immediately. A pending memory response is not tracked; the memory is reset on the same `rst`.
- **Handshake rule.** `ImemAddr` is unchanged and `ImemReq` stays high from request until `ImemReady`.

## Structure
- Shared package `pipeline_pkg`:
  - `pcsrc_t` enum: `PCSRC_PLUS4`, `PCSRC_TARGET`, `PCSRC_JALR`.
  - `fetch_state_t` enum: `FETCH`, `DROP`.
  - `NOP_INSTR` constant.
  - `ifid_t` struct: instr, pc, pcplus4, valid.
- One sub-module, `ifid_reg`: IF/ID register with hold and bubble inputs, reused for the skid buffer.

## Test plan
- **Reset, then sequential fetch.** `RESET_PC` = 0, `ImemReady` = 1, `PCSrcE` = 00 → `ImemAddr` 0, 4, 8; `PCD` 0, 4, 8 one cycle later, `ValidD` = 1.
- **Taken branch.** `PCSrcE` = 01, `PCTargetE` = 0x100 at PCF = 0x20 → next `ImemAddr` = 0x100; `ValidD` = 0 for one cycle; `PCD` = 0x100 after that.
- **JALR.** `PCSrcE` = 10, `ALUResultE` = 0x203 → `PCF` = 0x202.
- **Redirect during a wait.** `ImemReady` = 0 on addr 0x40; `PCSrcE` = 01 to 0x80; ready 3 cycles later with 0xDEADBEEF → `ImemAddr` stays 0x40 until ready; 0xDEADBEEF never appears with `ValidD` = 1; next request is 0x80.
- **Stall with skid buffer.** `StallD` = `StallF` = 1 while 0x8 is accepted → IF/ID holds its old value; the buffer holds 0x8 and `ImemReq` = 0. After release, `PCD` = 0x8 and the next request is 0xC.
- **Wrap-around and reset.** `PCF` = 0xFFFF_FFFC → next 0x0. `rst` pulsed mid-wait → `PCF` = `RESET_PC`, `ValidD` = 0.
